// File: rtl/bus_arbiter_2to1_pkg.sv
// bus_arbiter_2to1_pkg: OCP command/response encodings and arbiter types
// Contents:
//   Ocp_cmd                  master command encoding (IDLE/WR/RD)
//   Ocp_resp                 slave response encoding (NULL/DVA/FAIL/ERR)
//   Master_id                index of an upstream master (0 or 1)
//   BUS_ARB_MAX_OUTSTANDING  default depth of the response-order FIFO
package bus_arbiter_2to1_pkg;
    typedef enum logic [2:0] {IDLE = 3'd0, WR = 3'd1, RD = 3'd2} Ocp_cmd;
    typedef enum logic [1:0] {NULL = 2'd0, DVA = 2'd1, FAIL = 2'd2, ERR = 2'd3} Ocp_resp;
    typedef logic Master_id;
    localparam int BUS_ARB_MAX_OUTSTANDING = 4;
endpackage

// File: rtl/Bus_if.sv
// Bus_if: OCP-style request/response bundle between one master and one slave
// Signals:
//   MCmd/MAddr/MData/MDataValid/MByteEn  request, driven by the master
//   SCmdAccept/SDataAccept               request handshake, driven by the slave
//   SResp/SData                          response, driven by the slave
//   MRespAccept                          response handshake, driven by the master
//   MReset_n                             reset forwarded by the master
interface Bus_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    import bus_arbiter_2to1_pkg::*;
    Ocp_cmd                  MCmd;
    logic [ADDR_WIDTH-1:0]   MAddr;
    logic [DATA_WIDTH-1:0]   MData;
    logic                    MDataValid;
    logic [DATA_WIDTH/8-1:0] MByteEn;
    logic                    SCmdAccept;
    logic                    SDataAccept;
    Ocp_resp                 SResp;
    logic [DATA_WIDTH-1:0]   SData;
    logic                    MRespAccept;
    logic                    MReset_n;
    modport master (
        output MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept, MReset_n,
        input  SCmdAccept, SDataAccept, SResp, SData
    );
    modport slave (
        input  MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept, MReset_n,
        output SCmdAccept, SDataAccept, SResp, SData
    );
endinterface

// File: rtl/bus_arb_order_fifo.sv
// bus_arb_order_fifo: records which master issued each accepted command, oldest first
// Ports:
//   Clk, MReset_n  clock and synchronous active-low reset
//   push, push_id  append the id of a newly accepted command
//   pop            retire the oldest id (its response has been taken)
//   full, empty    derived from the registered occupancy only
//   head           id of the oldest outstanding command
module bus_arb_order_fifo
    import bus_arbiter_2to1_pkg::*;
#(
    parameter int DEPTH = BUS_ARB_MAX_OUTSTANDING
) (
    input  logic     Clk,
    input  logic     MReset_n,
    input  logic     push,
    input  Master_id push_id,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output Master_id head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    Master_id mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd_ptr];
    always_ff @(posedge Clk) begin
        if (!MReset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
`ifndef SYNTHESIS
    always @(posedge Clk) begin
        if (MReset_n) begin
            assert (!(push && full)) else $error("order fifo: push while full");
            assert (!(pop && empty)) else $error("order fifo: pop while empty");
        end
    end
`endif
endmodule

// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1: round-robin merge of two OCP masters onto one slave with in-order response return
// Ports:
//   Clk, MReset_n  clock and synchronous active-low reset
//   m0, m1         upstream masters (m0 wins the first contested arbitration after reset)
//   out            downstream slave side (feeds the bus delay stage)
module bus_arbiter_2to1
    import bus_arbiter_2to1_pkg::*;
#(
    parameter int MAX_OUTSTANDING = BUS_ARB_MAX_OUTSTANDING,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32
) (
    input logic  Clk,
    input logic  MReset_n,
    Bus_if.slave  m0,
    Bus_if.slave  m1,
    Bus_if.master out
);
    logic req0, req1, present, accept, resp_valid, routed, pop, full, empty, lock;
    Master_id grant, last_grant, lock_id, head;
    Ocp_cmd sel_cmd;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [DATA_WIDTH/8-1:0] sel_be;
    logic sel_dv;
    always_comb begin
        req0  = m0.MCmd != IDLE;
        req1  = m1.MCmd != IDLE;
        // a stalled request keeps its grant; otherwise round-robin on contention
        grant = lock ? lock_id : (req0 && req1) ? ~last_grant : Master_id'(req1);
        sel_cmd  = grant ? m1.MCmd       : m0.MCmd;
        sel_addr = grant ? m1.MAddr      : m0.MAddr;
        sel_data = grant ? m1.MData      : m0.MData;
        sel_be   = grant ? m1.MByteEn    : m0.MByteEn;
        sel_dv   = grant ? m1.MDataValid : m0.MDataValid;
        present  = MReset_n && (grant ? req1 : req0) && !full;
        accept   = present && out.SCmdAccept;
        out.MCmd       = present ? sel_cmd : IDLE;
        out.MAddr      = sel_addr;
        out.MData      = sel_data;
        out.MByteEn    = sel_be;
        out.MDataValid = sel_dv;
        out.MReset_n   = MReset_n;
        m0.SCmdAccept  = accept && !grant;
        m0.SDataAccept = accept && !grant;
        m1.SCmdAccept  = accept && grant;
        m1.SDataAccept = accept && grant;
        resp_valid = out.SResp != NULL;
        routed     = MReset_n && resp_valid && !empty;
        m0.SResp   = (routed && !head) ? out.SResp : NULL;
        m1.SResp   = (routed && head) ? out.SResp : NULL;
        m0.SData   = out.SData;
        m1.SData   = out.SData;
        // with nothing outstanding a stray response is swallowed rather than stalling the slave
        out.MRespAccept = MReset_n && (empty || (head ? m1.MRespAccept : m0.MRespAccept));
        pop = routed && out.MRespAccept;
    end
    always_ff @(posedge Clk) begin
        if (!MReset_n) begin
            last_grant <= 1'b1;
            lock       <= 1'b0;
            lock_id    <= 1'b0;
        end else if (accept) begin
            last_grant <= grant;
            lock       <= 1'b0;
        end else if (present) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end
    end
    bus_arb_order_fifo #(.DEPTH(MAX_OUTSTANDING)) u_order_fifo (
        .Clk      (Clk),
        .MReset_n (MReset_n),
        .push     (accept),
        .push_id  (grant),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );
`ifndef SYNTHESIS
    Master_id prev_grant;
    always @(posedge Clk) begin
        prev_grant <= grant;
        if (MReset_n) begin
            assert (!(resp_valid && empty)) else $error("arbiter: response with no outstanding command");
            assert (!lock || grant == prev_grant) else $error("arbiter: grant moved during a held request");
        end
    end
`endif
endmodule
